tisc_spi_flash_seq: RTL and testbench
=====================================

# tisc_spi_flash_seq

Command sequencer for the TISC SPI configuration-flash port. It drives the 4-register simple_spi core (SPCR/SPSR/SPDR/SPER) as a single WISHBONE master and owns CS_B. A caller can issue a complete flash transaction (opcode, optional 24-bit address, dummy bytes, N read bytes) with one `go_i` pulse instead of PCI-level byte banging. It sits inside tisc_identification, between its register file and simple_spi_top.

## Interface
- `SPCR_INIT`, 8'h50: value written to SPCR after reset (SPE=1, MSTR=1, mode 0, SPR=00).
- `TIMEOUT`, 16'hFFFF: maximum cycles spent waiting for any single ack or for SPSR.RFEMPTY to clear.
- `CS_GAP`, 4: minimum cycles CS_B stays high between transactions.
- `clk_i` in 1: WISHBONE clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `go_i` in 1: start pulse. Accepted only when `busy_o`=0.
- `cmd_i` in 8: flash opcode.
- `addr_i` in 24: flash address, sent MSB byte first.
- `addr_en_i` in 1: send the 3 address bytes.
- `dummy_i` in 4: number of dummy bytes (0–15), each transmitted as 8'h00.
- `rx_len_i` in 9: number of data bytes to read (0–511).
- `busy_o` out 1: a transaction or the init write is in progress.
- `rx_dat_o` out 8: received data byte.
- `rx_valid_o` out 1: one-cycle strobe marking `rx_dat_o` valid.
- `done_o` out 1: one-cycle pulse at the end of a transaction.
- `err_o` out 1: one-cycle pulse, coincident with `done_o`, when a timeout ended the transaction.
- `spi_cyc_o`, `spi_stb_o`, `spi_we_o` out 1 each: WISHBONE master strobes to simple_spi.
- `spi_adr_o` out 2: register select. 0=SPCR, 1=SPSR, 2=SPDR.
- `spi_dat_o` out 8: write data.
- `spi_dat_i` in 8: read data.
- `spi_ack_i` in 1: slave acknowledge.
- `cs_b_o` out 1: flash chip select, active low.

## Operation
- **Reset values:** `cs_b_o`=1. `spi_cyc_o`, `spi_stb_o`, `spi_we_o`, `rx_valid_o`, `done_o`, `err_o` = 0. `spi_adr_o`=0, `spi_dat_o`=0, `rx_dat_o`=0. `busy_o`=1 (init pending). State = INIT.
- **States:**
  - INIT: write SPCR_INIT to adr 0, then go to IDLE.
  - IDLE: `busy_o`=0. On `go_i`, latch all command inputs, compute the total byte count, go to CSLO.
  - CSLO: drive `cs_b_o`=0 for one cycle, then go to TX.
  - TX: write the current TX byte to adr 2, then go to POLL.
  - POLL: read adr 1. Repeat while `spi_dat_i[0]` (RFEMPTY) = 1. When it is 0, go to RX.
  - RX: read adr 2. Then go to TX if bytes remain, otherwise CSHI.
  - CSHI: set `cs_b_o`=1, pulse `done_o`, hold for CS_GAP cycles, then go to IDLE.
- **Byte order:** cmd, then addr[23:16], addr[15:8], addr[7:0] (only if `addr_en_i`), then `dummy_i`×8'h00, then `rx_len_i`×8'h00.
- **Total byte count:** 1 + 3·addr_en + dummy + rx_len, 9+1 bits wide, no overflow (max 530).
- **Received data:** every transmitted byte is read back from SPDR to drain the RX FIFO. `rx_valid_o` pulses only for bytes in the data phase, with `rx_dat_o` = SPDR value, in the cycle after the RX ack.
- **WISHBONE rules:**
  - Single accesses only.
  - `spi_cyc_o` and `spi_stb_o` rise together and hold with stable adr/dat/we until the cycle `spi_ack_i`=1. They drop the next cycle.
  - At least one idle cycle between accesses.
- **Timeout:** a 16-bit counter clears at each state entry and counts cycles waiting for an ack or in POLL. If it reaches TIMEOUT:
  - drop cyc/stb;
  - go to CSHI;
  - pulse `err_o` together with `done_o`;
  - return to INIT so that SPCR is rewritten.
- **Edge cases:**
  - `go_i` while busy: ignored, no queuing.
  - `rx_len_i`=0: command-only transaction (e.g. 0x06 WREN), no `rx_valid_o`.
  - Command inputs may change after `go_i`; they are latched.
- **Reset mid-transaction:** outputs return to reset values immediately and asynchronously. `cs_b_o` goes high without waiting for a clock, and INIT reruns.

## Timing
- After reset release, the INIT write completes and `busy_o` falls no earlier than 3 cycles later (slave with 1-cycle ack).
- From `go_i` to `cs_b_o` low: 2 cycles.
- Per byte with a 1-cycle-ack slave: TX 2 cycles + gap + POLL (≥2 per read) + RX 2 cycles.
- `done_o` is asserted in the same cycle that `cs_b_o` rises.
- `busy_o` stays high until CS_GAP cycles after `done_o`.

## Test plan
- **Reset/init:** release `rst_i` → exactly one write, adr=0, dat=8'h50; then `busy_o`=0 and `cs_b_o`=1.
- **Read ID:** cmd=8'h9F, addr_en=0, dummy=0, rx_len=3, slave SPDR returns FF,EF,40,18 → TX sequence 9F,00,00,00; `rx_valid_o` pulses 3 times with EF,40,18; one `done_o`; `err_o`=0; CS low across all 4 bytes.
- **Fast read:** cmd=8'h0B, addr=24'h123456, addr_en=1, dummy=1, rx_len=2 → TX sequence 0B,12,34,56,00,00,00; 2 `rx_valid_o` pulses.
- **WREN:** cmd=8'h06, rx_len=0 → a single TX byte 06; no `rx_valid_o`; `done_o` pulse; second `go_i` asserted while busy is ignored.
- **Timeout:** SPSR held at 8'h05 (RFEMPTY=1) with TIMEOUT=16 → `err_o` and `done_o` pulse together; `cs_b_o`=1; the SPCR 8'h50 rewrite is observed.
- **Async reset mid-byte:** assert `rst_i` during POLL of byte 2 → `cs_b_o`=1 and `spi_cyc_o`=0 before the next clock edge; the init sequence repeats.

Source files
------------

// File: rtl/tisc_spi_flash_seq.sv
// rtl/tisc_spi_flash_seq.sv - SPI flash command sequencer driving simple_spi over WISHBONE
// Sends opcode, optional address, dummy and read bytes as one CS_B-framed transaction.
module tisc_spi_flash_seq #(
  parameter logic [7:0]  SPCR_INIT = 8'h50,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF,
  parameter int          CS_GAP    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        go_i,
  input  logic [7:0]  cmd_i,
  input  logic [23:0] addr_i,
  input  logic        addr_en_i,
  input  logic [3:0]  dummy_i,
  input  logic [8:0]  rx_len_i,
  output logic        busy_o,
  output logic [7:0]  rx_dat_o,
  output logic        rx_valid_o,
  output logic        done_o,
  output logic        err_o,
  output logic        spi_cyc_o,
  output logic        spi_stb_o,
  output logic        spi_we_o,
  output logic [1:0]  spi_adr_o,
  output logic [7:0]  spi_dat_o,
  input  logic [7:0]  spi_dat_i,
  input  logic        spi_ack_i,
  output logic        cs_b_o
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_CSLO = 3'd2;
  localparam logic [2:0] S_TX   = 3'd3;
  localparam logic [2:0] S_POLL = 3'd4;
  localparam logic [2:0] S_RX   = 3'd5;
  localparam logic [2:0] S_CSHI = 3'd6;

  logic [2:0]  r_state;
  logic [7:0]  r_cmd;
  logic [23:0] r_addr;
  logic        r_addr_en;
  logic [9:0]  r_data_start;
  logic [9:0]  r_total;
  logic [9:0]  r_idx;
  logic [15:0] r_tmo;
  logic [7:0]  r_gap;
  logic        r_err_pend;
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [1:0]  r_adr;
  logic [7:0]  r_dat;
  logic [7:0]  r_rx_dat;
  logic        r_rx_valid;
  logic        r_done;
  logic        r_err;
  logic        r_cs_b;

  logic [7:0]  w_tx_byte;
  logic        w_acc_state;
  logic        w_acc_we;
  logic [1:0]  w_acc_adr;
  logic [7:0]  w_acc_dat;
  logic [9:0]  w_start;
  logic        w_in_data;
  logic        w_last;
  logic        w_tmo;

  assign w_start   = 10'd1 + (addr_en_i ? 10'd3 : 10'd0) + {6'd0, dummy_i};
  assign w_in_data = (r_idx >= r_data_start);
  assign w_last    = ((r_idx + 10'd1) == r_total);
  // >= so a poll ack landing on the limit still times out next cycle
  assign w_tmo     = (r_tmo >= (TIMEOUT - 16'd1));
  assign w_acc_state = (r_state == S_INIT) || (r_state == S_TX) ||
                       (r_state == S_POLL) || (r_state == S_RX);

  always_comb begin
    w_tx_byte = 8'h00;
    if (r_idx == 10'd0) begin
      w_tx_byte = r_cmd;
    end else if (r_addr_en && (r_idx <= 10'd3)) begin
      case (r_idx[1:0])
        2'd1:    w_tx_byte = r_addr[23:16];
        2'd2:    w_tx_byte = r_addr[15:8];
        default: w_tx_byte = r_addr[7:0];
      endcase
    end
  end

  always_comb begin
    w_acc_we  = 1'b0;
    w_acc_adr = 2'd2;
    w_acc_dat = 8'h00;
    case (r_state)
      S_INIT: begin w_acc_we = 1'b1; w_acc_adr = 2'd0; w_acc_dat = SPCR_INIT; end
      S_TX:   begin w_acc_we = 1'b1; w_acc_adr = 2'd2; w_acc_dat = w_tx_byte; end
      S_POLL: w_acc_adr = 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_INIT;      r_cmd <= 8'h00;         r_addr <= 24'h0;
      r_addr_en <= 1'b0;      r_data_start <= 10'd0;  r_total <= 10'd0;
      r_idx <= 10'd0;         r_tmo <= 16'd0;         r_gap <= 8'd0;
      r_err_pend <= 1'b0;     r_cyc <= 1'b0;          r_stb <= 1'b0;
      r_we <= 1'b0;           r_adr <= 2'd0;          r_dat <= 8'h00;
      r_rx_dat <= 8'h00;      r_rx_valid <= 1'b0;     r_done <= 1'b0;
      r_err <= 1'b0;          r_cs_b <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      if (w_acc_state) begin
        if (r_cyc && spi_ack_i) begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
          r_tmo <= 16'd0;
          case (r_state)
            S_INIT: r_state <= S_IDLE;
            S_TX:   r_state <= S_POLL;
            S_POLL: begin
              if (spi_dat_i[0]) r_tmo <= r_tmo + 16'd1;
              else              r_state <= S_RX;
            end
            default: begin
              if (w_in_data) begin
                r_rx_valid <= 1'b1;
                r_rx_dat   <= spi_dat_i;
              end
              r_idx <= r_idx + 10'd1;
              if (w_last) begin
                r_state <= S_CSHI;
                r_cs_b  <= 1'b1;
                r_done  <= 1'b1;
                r_gap   <= 8'd0;
              end else begin
                r_state <= S_TX;
              end
            end
          endcase
        end else if (w_tmo) begin
          r_cyc      <= 1'b0;
          r_stb      <= 1'b0;
          r_state    <= S_CSHI;
          r_cs_b     <= 1'b1;
          r_done     <= 1'b1;
          r_err      <= 1'b1;
          r_err_pend <= 1'b1;
          r_gap      <= 8'd0;
          r_tmo      <= 16'd0;
        end else begin
          r_tmo <= r_tmo + 16'd1;
          // cyc is low on the first cycle of every access, giving the idle gap
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= w_acc_we;
            r_adr <= w_acc_adr;
            r_dat <= w_acc_dat;
          end
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (go_i) begin
              r_cmd        <= cmd_i;
              r_addr       <= addr_i;
              r_addr_en    <= addr_en_i;
              r_data_start <= w_start;
              r_total      <= w_start + {1'b0, rx_len_i};
              r_idx        <= 10'd0;
              r_state      <= S_CSLO;
            end
          end
          S_CSLO: begin
            r_cs_b  <= 1'b0;
            r_tmo   <= 16'd0;
            r_state <= S_TX;
          end
          S_CSHI: begin
            if (r_gap == 8'(CS_GAP - 1)) begin
              r_state    <= r_err_pend ? S_INIT : S_IDLE;
              r_err_pend <= 1'b0;
              r_tmo      <= 16'd0;
            end else begin
              r_gap <= r_gap + 8'd1;
            end
          end
          default: r_state <= S_INIT;
        endcase
      end
    end
  end

  assign busy_o     = (r_state != S_IDLE);
  assign rx_dat_o   = r_rx_dat;
  assign rx_valid_o = r_rx_valid;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign spi_cyc_o  = r_cyc;
  assign spi_stb_o  = r_stb;
  assign spi_we_o   = r_we;
  assign spi_adr_o  = r_adr;
  assign spi_dat_o  = r_dat;
  assign cs_b_o     = r_cs_b;

endmodule

// File: tb/tb_tisc_spi_flash_seq.sv
// tb/tb_tisc_spi_flash_seq.sv - directed table-driven bench for tisc_spi_flash_seq
module tb_tisc_spi_flash_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [23:0] addr = 24'h0;
  logic        addr_en = 1'b0;
  logic [3:0]  dummy = 4'h0;
  logic [8:0]  rx_len = 9'h0;
  logic        busy, rx_valid, done, err, cyc, stb, we, cs_b;
  logic [7:0]  rx_dat, dat_o;
  logic [1:0]  adr;
  logic [7:0]  dat_i = 8'h00;
  logic        ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tisc_spi_flash_seq #(.SPCR_INIT(8'h50), .TIMEOUT(16'd16), .CS_GAP(4)) dut (
    .clk_i(clk), .rst_i(rst), .go_i(go), .cmd_i(cmd), .addr_i(addr),
    .addr_en_i(addr_en), .dummy_i(dummy), .rx_len_i(rx_len), .busy_o(busy),
    .rx_dat_o(rx_dat), .rx_valid_o(rx_valid), .done_o(done), .err_o(err),
    .spi_cyc_o(cyc), .spi_stb_o(stb), .spi_we_o(we), .spi_adr_o(adr),
    .spi_dat_o(dat_o), .spi_dat_i(dat_i), .spi_ack_i(ack), .cs_b_o(cs_b)
  );

  // simple_spi stand-in: registered 1-cycle ack, SPSR reports empty on every other poll
  logic [63:0] spdr_data = 64'h0;
  int          spdr_base = 0;
  int          spdr_ptr = 0;
  int          s_k;
  logic        spsr_stuck = 1'b0;
  logic        poll_tog = 1'b0;
  logic [1:0]  wr_adr_q[$];
  logic [7:0]  wr_dat_q[$];
  logic        wr_cs_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= 1'b0;
    end else begin
      ack <= cyc & stb & ~ack;
      if (cyc & stb & ~ack) begin
        if (we) begin
          wr_adr_q.push_back(adr);
          wr_dat_q.push_back(dat_o);
          wr_cs_q.push_back(cs_b);
        end else if (adr == 2'd1) begin
          dat_i    <= (spsr_stuck || !poll_tog) ? 8'h05 : 8'h04;
          poll_tog <= ~poll_tog;
        end else begin
          s_k = spdr_ptr - spdr_base;
          dat_i <= (s_k >= 0 && s_k < 8) ? spdr_data[63-8*s_k -: 8] : 8'h00;
          spdr_ptr <= spdr_ptr + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus/strobe monitor
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [7:0]  rx_q[$];
  logic        p_cyc = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_cs = 1'b1;
  logic [1:0]  p_adr = 2'd0;
  logic [7:0]  p_dat = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) rx_q.push_back(rx_dat);
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_with_cs_rise", {30'd0, cs_b, p_cs}, 32'h2);
      end
      if (err && !done) chk("err_without_done", 32'd1, 32'd0);
      if (cyc) begin
        chk("stb_eq_cyc", 32'(stb), 32'd1);
        if (p_cyc && !p_ack)
          chk("wb_stable", {21'd0, we, adr, dat_o}, {21'd0, p_we, p_adr, p_dat});
        if (p_cyc && p_ack) chk("wb_idle_gap", 32'(cyc), 32'd0);
      end
      p_cyc = cyc; p_ack = ack; p_we = we; p_adr = adr; p_dat = dat_o; p_cs = cs_b;
    end else begin
      p_cyc = 1'b0; p_ack = 1'b0; p_cs = 1'b1;
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic        addr_en;
    logic [3:0]  dummy;
    logic [8:0]  rx_len;
    logic [63:0] spdr;
    int          ntx;
    logic [63:0] tx;
    int          nrx;
    logic [23:0] rx;
  } vec_t;

  vec_t v[5];
  int   wb, rb, db, eb, j, n;

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic last_write_is_init(input string name);
    if (wr_dat_q.size() == 0) chk(name, 32'hDEAD, 32'h050);
    else chk(name, {22'd0, wr_adr_q[$], wr_dat_q[$]}, {22'd0, 2'd0, 8'h50});
  endtask

  initial begin
    v[0] = '{8'h9F, 24'h000000, 1'b0, 4'd0, 9'd3, 64'hFFEF4018_00000000, 4, 64'h9F000000_00000000, 3, 24'hEF4018};
    v[1] = '{8'h0B, 24'h123456, 1'b1, 4'd1, 9'd2, 64'hA0A1A2A3_A4A5A6A7, 7, 64'h0B123456_00000000, 2, 24'hA5A600};
    v[2] = '{8'h06, 24'h000000, 1'b0, 4'd0, 9'd0, 64'hFFFFFFFF_FFFFFFFF, 1, 64'h06000000_00000000, 0, 24'h000000};
    v[3] = '{8'h03, 24'hABCDEF, 1'b1, 4'd0, 9'd1, 64'h10111213_14151617, 5, 64'h03ABCDEF_00000000, 1, 24'h140000};
    v[4] = '{8'h5A, 24'hFFFFFF, 1'b0, 4'd2, 9'd1, 64'h20212223_24252627, 4, 64'h5A000000_00000000, 1, 24'h230000};

    // Reset values and init write
    repeat (3) @(negedge clk);
    chk("rst_cs_b", 32'(cs_b), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_strobes", {26'd0, cyc, stb, we, rx_valid, done, err}, 32'd0);
    chk("rst_adr_dat", {14'd0, adr, dat_o, rx_dat}, 32'd0);
    rst = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("init_latency_ge3", 32'(n >= 3 && n < 200), 32'd1);
    chk("init_write_count", 32'(wr_dat_q.size()), 32'd1);
    last_write_is_init("init_write");
    chk("init_cs_b", 32'(cs_b), 32'd1);

    // Table-driven transactions
    for (int t = 0; t < 5; t++) begin
      wb = wr_dat_q.size(); rb = rx_q.size(); db = done_cnt; eb = err_cnt;
      spdr_base = spdr_ptr; spdr_data = v[t].spdr;
      @(negedge clk);
      cmd = v[t].cmd; addr = v[t].addr; addr_en = v[t].addr_en;
      dummy = v[t].dummy; rx_len = v[t].rx_len; go = 1'b1;
      @(negedge clk);
      go = 1'b0; cmd = 8'hEE; addr = 24'h0; addr_en = ~v[t].addr_en;
      dummy = 4'hF; rx_len = 9'h1FF;
      chk($sformatf("v%0d_cs_go+1", t), 32'(cs_b), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_cs_go+2", t), 32'(cs_b), 32'd0);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_idle($sformatf("v%0d_idle", t));
      j = 0;
      for (int k = wb; k < wr_dat_q.size(); k++) begin
        if (j < v[t].ntx && j < 8) begin
          chk($sformatf("v%0d_tx%0d", t, j), {22'd0, wr_adr_q[k], wr_dat_q[k]},
              {22'd0, 2'd2, v[t].tx[63-8*j -: 8]});
          chk($sformatf("v%0d_tx%0d_cs", t, j), 32'(wr_cs_q[k]), 32'd0);
        end
        j++;
      end
      chk($sformatf("v%0d_tx_count", t), 32'(j), 32'(v[t].ntx));
      chk($sformatf("v%0d_rx_count", t), 32'(rx_q.size() - rb), 32'(v[t].nrx));
      for (int k = 0; k < v[t].nrx && (rb + k) < rx_q.size(); k++)
        chk($sformatf("v%0d_rx%0d", t, k), 32'(rx_q[rb+k]), 32'(v[t].rx[23-8*k -: 8]));
      chk($sformatf("v%0d_done_count", t), 32'(done_cnt - db), 32'd1);
      chk($sformatf("v%0d_err_count", t), 32'(err_cnt - eb), 32'd0);
    end

    // Timeout: SPSR stuck at RFEMPTY
    wb = wr_dat_q.size(); rb = rx_q.size(); db = done_cnt;
    spsr_stuck = 1'b1;
    @(negedge clk);
    cmd = 8'h9F; addr_en = 1'b0; dummy = 4'd0; rx_len = 9'd3; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!err && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_err_done_cs", {29'd0, err, done, cs_b}, 32'h7);
    spsr_stuck = 1'b0;
    wait_idle("tmo_idle");
    last_write_is_init("tmo_spcr_rewrite");
    chk("tmo_done_count", 32'(done_cnt - db), 32'd1);
    chk("tmo_no_rx", 32'(rx_q.size() - rb), 32'd0);

    // Asynchronous reset during POLL of byte 2
    wb = wr_dat_q.size();
    @(negedge clk);
    cmd = 8'h9F; rx_len = 9'd3; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!((wr_dat_q.size() - wb) == 2 && cyc && adr == 2'd1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ar_reached_poll2", {30'd0, cyc, cs_b}, 32'h2);
    #1 rst = 1'b1;
    #1;
    chk("ar_async_cs_cyc_busy", {29'd0, cs_b, cyc, busy}, 32'h5);
    @(negedge clk);
    wb = wr_dat_q.size();
    rst = 1'b0;
    wait_idle("ar_idle");
    chk("ar_init_count", 32'(wr_dat_q.size() - wb), 32'd1);
    last_write_is_init("ar_init_write");
    chk("ar_cs_b", 32'(cs_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
